// File: rtl/seq_add_sub_unit_pkg.sv
// rtl/seq_add_sub_unit_pkg.sv - shared FSM encodings, default sizes and helpers for seq_add_sub_unit
// Contents:
//   state_t            FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   DEF_WIDTH/CHUNK    default operand width and bits summed per clock
//   idx_bits()         slice-index counter width, never less than one bit
package seq_add_sub_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // A single-slice configuration still needs a one-bit index register.
    function automatic int idx_bits(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/seq_add_sub_unit_carry_select_slice.sv
// rtl/seq_add_sub_unit_carry_select_slice.sv - combinational CHUNK-bit carry-select slice adder
// Ports:
//   a, b   in   CHUNK  slice operands
//   cin    in   1      carry into the slice
//   sum    out  CHUNK  slice sum
//   cout   out  1      carry out of the slice
module carry_select_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] sum_c0;
    logic [CHUNK:0] sum_c1;

    // Both carry-in cases are formed up front so cin only drives the final mux.
    assign sum_c0 = {1'b0, a} + {1'b0, b};
    assign sum_c1 = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, 1'b1};

    assign sum  = cin ? sum_c1[CHUNK-1:0] : sum_c0[CHUNK-1:0];
    assign cout = cin ? sum_c1[CHUNK]     : sum_c0[CHUNK];

endmodule

// File: rtl/seq_add_sub_unit.sv
// rtl/seq_add_sub_unit.sv - multi-cycle add/subtract engine, one CHUNK-bit slice per clock
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_a, in_b operands, in_sub selects A-B
//   out_valid/out_ready  result handshake
//   out_sum              result modulo 2^WIDTH
//   out_carry            carry out of MSB (on subtract 1 = no borrow)
//   out_ovf              signed overflow
module seq_add_sub_unit
    import seq_add_sub_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int CHUNKS = WIDTH / CHUNK;
    localparam int IDXW   = idx_bits(CHUNKS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;

    assign slice_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign slice_b = b_q[int'(idx_q) * CHUNK +: CHUNK];

    carry_select_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        res_d       = res_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1: the +1 rides in as the first slice carry.
                    a_d        = in_a;
                    b_d        = in_sub ? ~in_b : in_b;
                    carry_d    = in_sub;
                    idx_d      = '0;
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                end
            end
            ST_RUN: begin
                sum_d[int'(idx_q) * CHUNK +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // Result registers only move here, so they hold steady outside DONE.
                    idx_d       = '0;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    res_d       = sum_d;
                    cout_d      = slice_cout;
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = res_q;
    assign out_carry = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_add_sub_unit.sv
// tb/tb_seq_add_sub_unit.sv - self-checking bench for seq_add_sub_unit
module tb_seq_add_sub_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_carry;
    logic        out_ovf;

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   hs_count = 0;

    always #5 clk = ~clk;

    seq_add_sub_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    always @(posedge clk) if (!rst && out_valid && out_ready) hs_count <= hs_count + 1;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [15:0] be;
        logic [16:0] full;
        exp_t e;
        be    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, be} + {16'd0, sub};
        e.sum = full[15:0];
        e.c   = full[16];
        e.v   = (a[15] == be[15]) && (full[15] != a[15]);
        return e;
    endfunction

    // Presents one operand bundle and returns just after the accepting edge.
    task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                            output bit ok);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges from the accepting edge until out_valid; -1 if it never rises.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = k; break; end
        end
    endtask

    task automatic handshake(input int stall);
        out_ready = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if ({out_sum, out_carry, out_ovf} !== 18'd0) begin
            bad++; $display("FAIL reset_outputs got sum=%h c=%b v=%b want 0/0/0", out_sum, out_carry, out_ovf);
        end
    endtask

    task automatic test_add;
        bit ok; int lat; exp_t e;
        exp_q.push_back('{sum: 16'h1235, c: 1'b0, v: 1'b0});
        drive_op(16'h1234, 16'h0001, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL add_accept got=timeout want=accepted"); end
        wait_valid(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d want=4", lat); end
        e = exp_q.pop_front();
        total++;
        if ({out_sum, out_carry, out_ovf} !== {e.sum, e.c, e.v}) begin
            bad++; $display("FAIL add_result got=%h/%b/%b want=%h/%b/%b", out_sum, out_carry, out_ovf, e.sum, e.c, e.v);
        end
        handshake(0);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL add_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic run_table(input string name, input logic [15:0] ta[], input logic [15:0] tb_[],
                             input logic ts[], input exp_t te[]);
        bit ok; int lat; exp_t e;
        for (int i = 0; i < ta.size(); i++) begin
            exp_q.push_back(te[i]);
            drive_op(ta[i], tb_[i], ts[i], ok);
            wait_valid(lat);
            e = exp_q.pop_front();
            total++;
            if (lat !== 4 || {out_sum, out_carry, out_ovf} !== {e.sum, e.c, e.v}) begin
                bad++;
                $display("FAIL %s[%0d] got=%h/%b/%b lat=%0d want=%h/%b/%b lat=4",
                         name, i, out_sum, out_carry, out_ovf, lat, e.sum, e.c, e.v);
            end
            handshake(i);
        end
    endtask

    task automatic test_sub;
        run_table("sub", '{16'h0000, 16'h0005}, '{16'h0001, 16'h0005}, '{1'b1, 1'b1},
                  '{'{16'hFFFF, 1'b0, 1'b0}, '{16'h0000, 1'b1, 1'b0}});
    endtask

    task automatic test_overflow;
        run_table("ovf", '{16'h7FFF, 16'h8000, 16'hFFFF}, '{16'h0001, 16'h0001, 16'hFFFF},
                  '{1'b0, 1'b1, 1'b0},
                  '{'{16'h8000, 1'b0, 1'b1}, '{16'h7FFF, 1'b1, 1'b1}, '{16'hFFFE, 1'b1, 1'b0}});
    endtask

    task automatic test_backpressure;
        bit ok; int lat; exp_t e;
        logic [17:0] held;
        exp_q.push_back('{sum: 16'h3333, c: 1'b0, v: 1'b0});
        drive_op(16'h1111, 16'h2222, 1'b0, ok);
        wait_valid(lat);
        held = {out_sum, out_carry, out_ovf};
        in_a = 16'hAAAA; in_b = 16'h5555; in_sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_sum, out_carry, out_ovf} !== held) begin
                bad++;
                $display("FAIL stall_hold[%0d] got valid=%b ready=%b out=%h want valid=1 ready=0 out=%h",
                         i, out_valid, in_ready, {out_sum, out_carry, out_ovf}, held);
            end
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        total++;
        if ({out_sum, out_carry, out_ovf} !== {e.sum, e.c, e.v}) begin
            bad++; $display("FAIL stall_result got=%h/%b/%b want=%h/%b/%b", out_sum, out_carry, out_ovf, e.sum, e.c, e.v);
        end
        handshake(0);
        repeat (8) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_accept got valid=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid_run;
        bit ok; int lat; exp_t e;
        drive_op(16'h1234, 16'h1111, 1'b0, ok);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0000) begin
            bad++; $display("FAIL midrst_state got ready=%b valid=%b sum=%h want 1/0/0000", in_ready, out_valid, out_sum);
        end
        exp_q.push_back('{sum: 16'h0100, c: 1'b0, v: 1'b0});
        drive_op(16'h00FF, 16'h0001, 1'b0, ok);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 4 || {out_sum, out_carry, out_ovf} !== {e.sum, e.c, e.v}) begin
            bad++; $display("FAIL midrst_next got=%h/%b/%b lat=%0d want=%h/%b/%b lat=4",
                            out_sum, out_carry, out_ovf, lat, e.sum, e.c, e.v);
        end
        handshake(1);
    endtask

    task automatic test_random;
        bit ok; int lat; int errs; int hs_start; exp_t e;
        logic [15:0] a, b; logic s;
        errs = 0;
        hs_start = hs_count;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
            if (i % 50 == 0) a = 16'h8000;
            exp_q.push_back(model(a, b, s));
            drive_op(a, b, s, ok);
            wait_valid(lat);
            e = exp_q.pop_front();
            total++;
            if (lat !== 4 || {out_sum, out_carry, out_ovf} !== {e.sum, e.c, e.v}) begin
                bad++; errs++;
                if (errs <= 10)
                    $display("FAIL rand[%0d] a=%h b=%h sub=%b got=%h/%b/%b lat=%0d want=%h/%b/%b lat=4",
                             i, a, b, s, out_sum, out_carry, out_ovf, lat, e.sum, e.c, e.v);
            end
            handshake($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        total++;
        if (hs_count - hs_start !== 1000 || exp_q.size() !== 0) begin
            bad++; $display("FAIL rand_count got results=%0d left=%0d want results=1000 left=0",
                            hs_count - hs_start, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
